// File: rtl/pulse_stretcher_pkg.sv
// Shared state encoding and width helper for the pulse stretcher.
package pulse_stretcher_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_HIGH = 2'b01,
    ST_LOW  = 2'b10
  } state_e;

  // Phase counter must hold the larger of the two phase lengths.
  function automatic int phase_cnt_w(input int high_cycles, input int low_cycles);
    return $clog2(((high_cycles > low_cycles) ? high_cycles : low_cycles) + 1);
  endfunction

endpackage

// File: rtl/pulse_stretcher_sat_cnt.sv
// Saturating up/down counter for queued strobes; an increment at full is
// dropped and reported by a one-cycle registered overflow strobe.
module sat_updown_counter #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_inc,
  input  logic         i_dec,
  output logic [W-1:0] o_count,
  output logic         o_overflow
);

  localparam logic [W-1:0] ONE = W'(1);

  logic [W-1:0] r_count;
  logic         r_overflow;
  logic         w_full;

  assign w_full = &r_count;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_overflow <= 1'b0;
      // Simultaneous inc and dec cancel, so a full queue can still accept.
      if (i_inc && !i_dec) begin
        if (w_full) r_overflow <= 1'b1;
        else        r_count    <= r_count + ONE;
      end else if (i_dec && !i_inc && (r_count != '0)) begin
        r_count <= r_count - ONE;
      end
    end
  end

  assign o_count    = r_count;
  assign o_overflow = r_overflow;

endmodule

// File: rtl/pulse_stretcher.sv
// Stretches single-cycle strobes into HIGH_CYCLES-wide pulses separated by at
// least LOW_CYCLES low cycles; strobes arriving mid-pulse are queued and replayed.
module pulse_stretcher
  import pulse_stretcher_pkg::*;
#(
  parameter int HIGH_CYCLES = 4,
  parameter int LOW_CYCLES  = 2,
  parameter int PEND_W      = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pulse_in,
  output logic              level_out,
  output logic              busy,
  output logic [PEND_W-1:0] pending,
  output logic              overflow
);

  localparam int CW = phase_cnt_w(HIGH_CYCLES, LOW_CYCLES);
  localparam logic [CW-1:0] HIGH_LD = CW'(HIGH_CYCLES);
  localparam logic [CW-1:0] LOW_LD  = CW'(LOW_CYCLES);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  state_e            r_state, w_state_nxt;
  logic [CW-1:0]     r_cnt, w_cnt_nxt;
  logic              r_level, r_busy;
  logic              w_last, w_have_pend, w_inc, w_dec;
  logic [PEND_W-1:0] w_pending;
  logic              w_overflow;

  assign w_last      = (r_cnt == CNT_ONE);
  assign w_have_pend = |w_pending;

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_inc       = 1'b0;
    w_dec       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (pulse_in) begin
          w_state_nxt = ST_HIGH;
          w_cnt_nxt   = HIGH_LD;
        end
      end
      ST_HIGH: begin
        w_inc = pulse_in;
        if (w_last) begin
          w_state_nxt = ST_LOW;
          w_cnt_nxt   = LOW_LD;
        end else begin
          w_cnt_nxt = r_cnt - CNT_ONE;
        end
      end
      ST_LOW: begin
        if (w_last) begin
          // Queued strobes restart first; a fresh strobe then takes its place.
          if (pulse_in || w_have_pend) begin
            w_state_nxt = ST_HIGH;
            w_cnt_nxt   = HIGH_LD;
            w_dec       = w_have_pend;
            w_inc       = pulse_in && w_have_pend;
          end else begin
            w_state_nxt = ST_IDLE;
            w_cnt_nxt   = '0;
          end
        end else begin
          w_inc     = pulse_in;
          w_cnt_nxt = r_cnt - CNT_ONE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_level <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_level <= (w_state_nxt == ST_HIGH);
      r_busy  <= (w_state_nxt != ST_IDLE);
    end
  end

  sat_updown_counter #(
    .W(PEND_W)
  ) u_pend (
    .clk        (clk),
    .rst        (rst),
    .i_inc      (w_inc),
    .i_dec      (w_dec),
    .o_count    (w_pending),
    .o_overflow (w_overflow)
  );

  assign level_out = r_level;
  assign busy      = r_busy;
  assign pending   = w_pending;
  assign overflow  = w_overflow;

endmodule
